freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Gated frequency counter: counts rising edges of an asynchronous input over a
//  fixed gate of GATE_CYCLES iClk cycles (1 s at 1 MHz by default) and reports Hz.
//  Receiving end of the divided-clock path: verifies/measures slow clocks and
//  external pulse trains, and feeds the display/readout logic.
// PARAMETERS
//  GATE_CYCLES  1_000_000  iClk cycles per measurement gate (>=2)
//  GATE_W       20         gate counter width; 2**GATE_W > GATE_CYCLES-1
//  CNT_W        20         edge counter / result width
// PORTS
//  iClk     in   1      system clock (1 MHz nominal)
//  iRst     in   1      async reset, active-high
//  iSig     in   1      signal to measure, asynchronous to iClk
//  iStart   in   1      start one measurement (sampled in IDLE only)
//  iCont    in   1      continuous mode: re-arm gate after every result
//  oFreq    out  CNT_W  last result, edges per gate (held until next result)
//  oOvf     out  1      last result saturated
//  oValid   out  1      one-cycle pulse: oFreq/oOvf just updated
//  oBusy    out  1      high in GATE and DONE
// BEHAVIOUR
//  Reset (async, iRst=1): oFreq=0, oOvf=0, oValid=0, oBusy=0, state=IDLE,
//   sync FFs, edge-history FF, gate and edge counters all 0.
//  Input path: 2-FF synchronizer then edge-history FF; rise = s2 & ~s3.
//   An iSig rise reaches the edge counter 3 iClk cycles later.
//   Max measurable rate iClk/2; faster inputs alias (not flagged).
//  FSM states: IDLE, GATE, DONE.
//   IDLE: oBusy=0. If iStart|iCont -> GATE; gate_cnt=0, edge_cnt=0, ovf=0.
//   GATE: gate_cnt++ each cycle; on rise, edge_cnt++ unless edge_cnt is all-1s,
//    in which case edge_cnt holds and ovf=1. After exactly GATE_CYCLES GATE
//    cycles (gate_cnt==GATE_CYCLES-1) -> DONE; a rise in that last cycle counts.
//    Transition also registers oFreq<=final edge_cnt, oOvf<=final ovf.
//   DONE (exactly 1 cycle): oValid=1. Rises here are not counted (dead cycle).
//    iCont=1 -> GATE (counters cleared as above); else -> IDLE.
//  Latency: iStart seen in IDLE at cycle T -> oValid at T+GATE_CYCLES+1.
//  Continuous results are spaced exactly GATE_CYCLES+1 cycles apart.
//  iStart during GATE/DONE ignored. Dropping iCont mid-gate completes the
//   current gate, then returns to IDLE.
//  oValid is high only in DONE; oFreq/oOvf change only on GATE->DONE.
//  Reset mid-gate: immediate abort to reset values; no partial result.
// TESTING (bench uses GATE_CYCLES=1000, iClk period 1 us)
//  1. iSig period 10 cycles, iStart pulse -> one oValid, oFreq=100, oOvf=0,
//     oValid exactly 1001 cycles after iStart sampled.
//  2. iSig held 0, then held 1 -> oFreq=0 both runs (level is not an edge).
//  3. iSig toggled every cycle (iClk/2) -> oFreq=500.
//  4. CNT_W=6, iSig period 4 -> oFreq=63, oOvf=1; next run at period 100 ->
//     oFreq=10, oOvf=0.
//  5. iCont=1, iSig period 20 -> oValid every 1001 cycles, oFreq=50 each;
//     drop iCont mid-gate -> one more result, then oBusy=0.
//  6. iRst pulse at gate cycle 500 -> all outputs 0, IDLE; fresh iStart gives
//     full-length correct result; iStart mid-gate has no effect.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of iSig over a
// fixed gate of GATE_CYCLES clocks and reports the count as the frequency.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 1_000_000,
  parameter int unsigned GATE_W      = 20,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSig,
  input  logic             iStart,
  input  logic             iCont,
  output logic [CNT_W-1:0] oFreq,
  output logic             oOvf,
  output logic             oValid,
  output logic             oBusy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        nextState;
  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              rise;
  logic [GATE_W-1:0] gateCnt;
  logic [CNT_W-1:0]  edgeCnt;
  logic [CNT_W-1:0]  edgeNext;
  logic              ovf;
  logic              ovfNext;

  // Two-stage synchronizer plus edge-history stage for rise detection
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= iSig;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state plus the saturating edge-count update for this cycle
  always_comb begin
    nextState = state;
    edgeNext  = edgeCnt;
    ovfNext   = ovf;
    if (rise) begin
      if (&edgeCnt) ovfNext  = 1'b1;
      else          edgeNext = edgeCnt + CNT_W'(1);
    end
    case (state)
      IDLE:    if (iStart || iCont) nextState = GATE;
      GATE:    if (gateCnt == GATE_LAST) nextState = DONE;
      DONE:    nextState = iCont ? GATE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Counters run only inside the gate and sit cleared otherwise
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      gateCnt <= '0;
      edgeCnt <= '0;
      ovf     <= 1'b0;
    end else if (state != GATE) begin
      gateCnt <= '0;
      edgeCnt <= '0;
      ovf     <= 1'b0;
    end else begin
      gateCnt <= gateCnt + GATE_W'(1);
      edgeCnt <= edgeNext;
      ovf     <= ovfNext;
    end
  end

  // Result captured on the closing gate cycle, including a rise in that cycle
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oFreq  <= '0;
      oOvf   <= 1'b0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
    end else begin
      oValid <= (nextState == DONE);
      oBusy  <= (nextState != IDLE);
      if (state == GATE && nextState == DONE) begin
        oFreq <= edgeNext;
        oOvf  <= ovfNext;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (20-bit and 6-bit result) share inputs and
// are checked against a count of rises taken from the recorded iSig samples.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int unsigned GC   = 1000;
  localparam int unsigned HIST = 40000;
  localparam int unsigned MAXA = (1 << 20) - 1;
  localparam int unsigned MAXB = (1 << 6) - 1;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sig   = 1'b0;
  logic        start = 1'b0;
  logic        cont  = 1'b0;
  logic [19:0] freqA;
  logic        ovfA, validA, busyA;
  logic [5:0]  freqB;
  logic        ovfB, validB, busyB;

  freq_meter #(.GATE_CYCLES(GC), .GATE_W(20), .CNT_W(20)) dut (
    .iClk(clk), .iRst(rst), .iSig(sig), .iStart(start), .iCont(cont),
    .oFreq(freqA), .oOvf(ovfA), .oValid(validA), .oBusy(busyA));

  freq_meter #(.GATE_CYCLES(GC), .GATE_W(10), .CNT_W(6)) dut6 (
    .iClk(clk), .iRst(rst), .iSig(sig), .iStart(start), .iCont(cont),
    .oFreq(freqB), .oOvf(ovfB), .oValid(validB), .oBusy(busyB));

  always #500 clk = ~clk;

  int cyc = 0;
  bit sigHist [HIST];

  // Record the iSig value seen at every rising edge, indexed by edge number
  always @(posedge clk) begin
    if (cyc < int'(HIST)) sigHist[cyc] = sig;
    cyc = cyc + 1;
  end

  int sigMode = 0;
  bit sigLevel = 1'b0;
  int period = 10;
  int ph = 0;

  always @(negedge clk) begin
    case (sigMode)
      0: sig = sigLevel;
      1: begin
        sig = (ph < period / 2);
        ph  = (ph + 1) % period;
      end
      default: sig = 1'($urandom_range(0, 1));
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rises sampled at edges ts-1 .. ts+GC-2 land in the gate after sync latency
  function automatic int unsigned modelCount(input int ts);
    int unsigned n = 0;
    for (int k = ts - 1; k <= ts + int'(GC) - 2; k++)
      if (sigHist[k] && !sigHist[k-1]) n++;
    return n;
  endfunction

  task automatic startRun(output int ts);
    @(negedge clk);
    start = 1'b1;
    ts = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitValid(input int budget, output int vEdge);
    vEdge = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (validA) begin
        vEdge = cyc - 1;
        break;
      end
    end
    check("valid_seen", 32'(vEdge >= 0), 32'd1);
  endtask

  task automatic checkResult(input string tag, input int ts, input int vEdge);
    int unsigned n;
    n = modelCount(ts);
    check({tag, "_latency"}, 32'(vEdge), 32'(ts + int'(GC)));
    check({tag, "_freqA"}, 32'(freqA), (n > MAXA) ? MAXA : n);
    check({tag, "_ovfA"}, 32'(ovfA), 32'(n > MAXA));
    check({tag, "_freqB"}, 32'(freqB), (n > MAXB) ? MAXB : n);
    check({tag, "_ovfB"}, 32'(ovfB), 32'(n > MAXB));
    check({tag, "_validB"}, 32'(validB), 32'd1);
    check({tag, "_busy"}, 32'(busyA), 32'd1);
  endtask

  task automatic expectNoValid(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (validA || validB) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic oneRun(input string tag, output int ts);
    int v;
    startRun(ts);
    check({tag, "_busy_start"}, 32'(busyA), 32'd1);
    waitValid(int'(GC) + 100, v);
    checkResult(tag, ts, v);
  endtask

  initial begin
    int ts, v;

    repeat (3) @(negedge clk);
    check("rst_freq", 32'(freqA), 32'd0);
    check("rst_ovf", 32'(ovfA), 32'd0);
    check("rst_valid", 32'(validA), 32'd0);
    check("rst_busy", 32'(busyA), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Period-10 input, single shot
    sigMode = 1; period = 10;
    repeat (20) @(negedge clk);
    oneRun("t1", ts);
    check("t1_freq_100", 32'(freqA), 32'd100);
    @(negedge clk);
    check("t1_valid_pulse", 32'(validA), 32'd0);
    check("t1_idle_busy", 32'(busyA), 32'd0);

    // Steady levels are not edges
    sigMode = 0; sigLevel = 1'b0;
    repeat (10) @(negedge clk);
    oneRun("t2lo", ts);
    check("t2lo_freq_0", 32'(freqA), 32'd0);
    sigLevel = 1'b1;
    repeat (10) @(negedge clk);
    oneRun("t2hi", ts);
    check("t2hi_freq_0", 32'(freqA), 32'd0);

    // Toggle every cycle
    sigMode = 1; period = 2; ph = 0;
    repeat (10) @(negedge clk);
    oneRun("t3", ts);
    check("t3_freq_500", 32'(freqA), 32'd500);

    // Saturation in the 6-bit instance, then recovery
    period = 4;
    repeat (20) @(negedge clk);
    oneRun("t4a", ts);
    check("t4a_freqB_63", 32'(freqB), 32'd63);
    check("t4a_ovfB_1", 32'(ovfB), 32'd1);
    period = 100;
    repeat (20) @(negedge clk);
    oneRun("t4b", ts);
    check("t4b_freqB_10", 32'(freqB), 32'd10);
    check("t4b_ovfB_0", 32'(ovfB), 32'd0);

    // Continuous mode, then drop iCont mid-gate
    period = 20;
    repeat (20) @(negedge clk);
    @(negedge clk);
    cont = 1'b1;
    ts = cyc;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) begin
        repeat (300) @(negedge clk);
        cont = 1'b0;
      end
      waitValid(int'(GC) + 100, v);
      checkResult("t5", ts, v);
      check("t5_freq_50", 32'(freqA), 32'd50);
      ts = v + 1;
    end
    @(negedge clk);
    check("t5_busy_after", 32'(busyA), 32'd0);
    check("t5_valid_after", 32'(validA), 32'd0);
    expectNoValid("t5_no_more", 1200);

    // Reset mid-gate aborts; restart ignores a mid-gate iStart
    period = 10;
    startRun(ts);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_freqA", 32'(freqA), 32'd0);
    check("t6_rst_freqB", 32'(freqB), 32'd0);
    check("t6_rst_ovf", 32'(ovfA), 32'd0);
    check("t6_rst_valid", 32'(validA), 32'd0);
    check("t6_rst_busy", 32'(busyA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expectNoValid("t6_no_partial", 1100);
    startRun(ts);
    repeat (400) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitValid(int'(GC) + 100, v);
    checkResult("t6", ts, v);
    check("t6_freq_100", 32'(freqA), 32'd100);
    expectNoValid("t6_start_ignored", 1100);
    check("t6_idle_busy", 32'(busyA), 32'd0);

    // Randomized inputs: random periods and random bit streams
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 1) == 0) begin
        sigMode = 1;
        period = int'($urandom_range(2, 40));
        ph = 0;
      end else begin
        sigMode = 2;
      end
      repeat (int'($urandom_range(5, 30))) @(negedge clk);
      oneRun("t7", ts);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
